// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared constants for the I2C timebase: bus-rate divisors at 64 MHz,
// default compare limits and compare channel assignments.
package tqvp_dlmiles_i2c_pkg;

  localparam int unsigned DIV_FASTPLUS = 3;
  localparam int unsigned DIV_FAST     = 9;
  localparam int unsigned DIV_STANDARD = 39;
  localparam int unsigned DIV_SLOW     = 399;

  localparam int unsigned CMP_EDGEWAIT = 2;
  localparam int unsigned CMP_PREWAIT  = 6;
  localparam int unsigned CMP_SCLHIGH  = 7;
  localparam int unsigned CMP_SCLLOW   = 9;
  localparam int unsigned CMP_TIMEOUT  = 511;

  localparam int unsigned CH_EDGEWAIT = 0;
  localparam int unsigned CH_PREWAIT  = 1;
  localparam int unsigned CH_SCLHIGH  = 2;
  localparam int unsigned CH_SCLLOW   = 3;
  localparam int unsigned CH_TIMEOUT  = 4;
  localparam int unsigned NUM_CH      = 5;

  localparam int unsigned SUBTICK_W = 4;

endpackage

// File: rtl/tqvp_dlmiles_i2c_prescaler.sv
// Programmable clock prescaler: emits one tick every div_limit_i+1 running clocks.
module tqvp_dlmiles_i2c_prescaler #(
  parameter int unsigned DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_limit_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Divisor is sampled only on reload, so a new limit waits for the current period.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (run_i) begin
      if (div_cnt_q == '0) div_cnt_d = div_limit_i;
      else                 div_cnt_d = div_cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  assign tick_o = run_i && (div_cnt_q == '0);

endmodule

// File: rtl/tqvp_dlmiles_i2c_timebase.sv
// I2C timebase: prescaler, tick counter with overflow flag, pulse/sticky
// compare channels and an SCL idle / not-idle monitor.
module tqvp_dlmiles_i2c_timebase
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned DIV_W  = 10,
  parameter int unsigned NCMP   = NUM_CH,
  parameter int unsigned IDLE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  timer_run_i,
  input  logic                  timer_clear_i,
  input  logic [DIV_W-1:0]      div_limit_i,
  input  logic [NCMP*CNT_W-1:0] cmp_limit_i,
  input  logic [NCMP-1:0]       cmp_sticky_i,
  output logic                  stb_tick_o,
  output logic [NCMP-1:0]       stb_cmp_o,
  output logic                  stb_first_o,
  output logic                  stb_overflow_o,
  output logic [CNT_W-1:0]      count_o,
  input  logic                  scl_i,
  input  logic                  idle_reset_i,
  input  logic                  idle_arm_i,
  input  logic [IDLE_W-1:0]     idle_limit_i,
  output logic                  idle_strobe_o,
  output logic                  idle_notidle_o
);

  logic tick;
  logic tick_eff;

  tqvp_dlmiles_i2c_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .run_i      (timer_run_i),
    .clear_i    (timer_clear_i),
    .div_limit_i(div_limit_i),
    .tick_o     (tick)
  );

  assign stb_tick_o = tick;
  // A clear swallows a coincident tick for the counter and compare channels.
  assign tick_eff   = tick && !timer_clear_i;

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             first_q, first_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    first_d = 1'b0;
    if (timer_clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (tick_eff) begin
      count_d = count_q + CNT_W'(1);
      if (&count_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  assign count_o        = count_q;
  assign stb_overflow_o = ovf_q;
  assign stb_first_o    = first_q;

  for (genvar k = 0; k < NCMP; k++) begin : g_cmp
    logic hit;
    logic sticky_q, sticky_d;

    assign hit = tick_eff && (count_q == cmp_limit_i[k*CNT_W +: CNT_W]);

    always_comb begin
      sticky_d = sticky_q;
      if (timer_clear_i)                 sticky_d = 1'b0;
      else if (cmp_sticky_i[k] && hit)   sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
    end

    assign stb_cmp_o[k] = cmp_sticky_i[k] ? sticky_q : hit;
  end

  logic [SUBTICK_W-1:0] sub_q, sub_d;
  logic [IDLE_W-1:0]    unit_q, unit_d;
  logic                 notidle_q, notidle_d;

  // Idle measurement counts ticks of continuous SCL high, in 16-tick units.
  always_comb begin
    sub_d     = sub_q;
    unit_d    = unit_q;
    notidle_d = notidle_q;
    if (!scl_i || idle_reset_i) begin
      sub_d  = '0;
      unit_d = '0;
    end else if (tick) begin
      sub_d = sub_q + SUBTICK_W'(1);
      if ((&sub_q) && !(&unit_q)) unit_d = unit_q + IDLE_W'(1);
    end
    if (!idle_arm_i)  notidle_d = 1'b0;
    else if (!scl_i)  notidle_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q     <= '0;
      unit_q    <= '0;
      notidle_q <= 1'b0;
    end else begin
      sub_q     <= sub_d;
      unit_q    <= unit_d;
      notidle_q <= notidle_d;
    end
  end

  assign idle_strobe_o  = scl_i && (unit_q >= idle_limit_i);
  assign idle_notidle_o = notidle_q;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_timebase.sv
// Scoreboard bench for the I2C timebase: a tick/idle-time reference model
// predicts every cycle's outputs, and a negedge monitor compares them.
module tb_tqvp_dlmiles_i2c_timebase;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DIV_W  = 10;
  localparam int unsigned NCMP   = 5;
  localparam int unsigned IDLE_W = 4;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int UNIT_MAX = (1 << IDLE_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  run;
  logic                  clear;
  logic [DIV_W-1:0]      div_limit;
  logic [NCMP*CNT_W-1:0] cmp_limit;
  logic [NCMP-1:0]       cmp_sticky;
  logic                  scl;
  logic                  idle_reset;
  logic                  arm;
  logic [IDLE_W-1:0]     idle_limit;

  logic              stb_tick;
  logic [NCMP-1:0]   stb_cmp;
  logic              stb_first;
  logic              stb_overflow;
  logic [CNT_W-1:0]  count;
  logic              idle_strobe;
  logic              idle_notidle;

  tqvp_dlmiles_i2c_timebase #(
    .CNT_W(CNT_W), .DIV_W(DIV_W), .NCMP(NCMP), .IDLE_W(IDLE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timer_run_i   (run),
    .timer_clear_i (clear),
    .div_limit_i   (div_limit),
    .cmp_limit_i   (cmp_limit),
    .cmp_sticky_i  (cmp_sticky),
    .stb_tick_o    (stb_tick),
    .stb_cmp_o     (stb_cmp),
    .stb_first_o   (stb_first),
    .stb_overflow_o(stb_overflow),
    .count_o       (count),
    .scl_i         (scl),
    .idle_reset_i  (idle_reset),
    .idle_arm_i    (arm),
    .idle_limit_i  (idle_limit),
    .idle_strobe_o (idle_strobe),
    .idle_notidle_o(idle_notidle)
  );

  typedef struct {
    logic             tick;
    logic [NCMP-1:0]  cmp;
    logic             first;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic             istb;
    logic             inot;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: clocks until the next tick, total ticks since clear,
  // ticks of continuous SCL high, and per-channel latched hits.
  int              wait_left  = 0;
  int              ticks      = 0;
  int              high_ticks = 0;
  logic [NCMP-1:0] seen       = '0;
  logic            m_first    = 1'b1;
  logic            m_notidle  = 1'b0;

  function automatic int lim(input int k);
    return int'(cmp_limit[k*CNT_W +: CNT_W]);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic t;
    int   cnt;
    int   units;
    t     = run && (wait_left == 0);
    cnt   = ticks % CNT_MOD;
    units = (high_ticks / 16 > UNIT_MAX) ? UNIT_MAX : high_ticks / 16;
    e.tick = t;
    for (int k = 0; k < NCMP; k++)
      e.cmp[k] = cmp_sticky[k] ? seen[k] : (t && !clear && cnt == lim(k));
    e.first = m_first;
    e.ovf   = (ticks >= CNT_MOD);
    e.count = CNT_W'(cnt);
    e.istb  = scl && (units >= int'(idle_limit));
    e.inot  = m_notidle;
    return e;
  endfunction

  function automatic void advance();
    logic t;
    int   cnt;
    t   = run && (wait_left == 0);
    cnt = ticks % CNT_MOD;
    if (rst) begin
      wait_left = 0; ticks = 0; high_ticks = 0;
      seen = '0; m_notidle = 1'b0; m_first = 1'b1;
      return;
    end
    m_first = 1'b0;
    if (clear) begin
      wait_left = 0; ticks = 0; seen = '0;
    end else if (run) begin
      if (t) begin
        for (int k = 0; k < NCMP; k++)
          if (cmp_sticky[k] && cnt == lim(k)) seen[k] = 1'b1;
        ticks++;
        wait_left = int'(div_limit);
      end else begin
        wait_left--;
      end
    end
    if (!scl || idle_reset) high_ticks = 0;
    else if (t)             high_ticks++;
    if (!arm)      m_notidle = 1'b0;
    else if (!scl) m_notidle = 1'b1;
  endfunction

  // Push this cycle's expectation, then step the model across the clock edge.
  task automatic cycle();
    sb_q.push_back(predict());
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("stb_tick",       int'(stb_tick),     int'(mon_e.tick));
      chk("stb_cmp",        int'(stb_cmp),      int'(mon_e.cmp));
      chk("stb_first",      int'(stb_first),    int'(mon_e.first));
      chk("stb_overflow",   int'(stb_overflow), int'(mon_e.ovf));
      chk("count_o",        int'(count),        int'(mon_e.count));
      chk("idle_strobe",    int'(idle_strobe),  int'(mon_e.istb));
      chk("idle_notidle",   int'(idle_notidle), int'(mon_e.inot));
    end
  end

  initial begin
    rst = 1'b1; run = 1'b1; clear = 1'b0; div_limit = '0;
    cmp_limit = '0; cmp_sticky = '0; scl = 1'b1; idle_reset = 1'b0;
    arm = 1'b0; idle_limit = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then release.
    cycles(3);
    rst = 1'b0;

    // Divide by 10; channel 0 pulse at 2, channel 1 sticky at 6.
    div_limit = DIV_W'(9);
    cmp_limit[0*CNT_W +: CNT_W] = CNT_W'(2);
    cmp_limit[1*CNT_W +: CNT_W] = CNT_W'(6);
    cmp_limit[2*CNT_W +: CNT_W] = CNT_W'(7);
    cmp_limit[3*CNT_W +: CNT_W] = CNT_W'(9);
    cmp_limit[4*CNT_W +: CNT_W] = CNT_W'(31);
    cmp_sticky = NCMP'(5'b00010);
    cycles(90);
    clear = 1'b1; cycle(); clear = 1'b0;
    cycles(15);

    // Tick every clock through a counter wrap, then clear on a hit tick.
    div_limit = '0;
    cycles(45);
    cmp_limit[0*CNT_W +: CNT_W] = CNT_W'(ticks % CNT_MOD);
    clear = 1'b1; cycle(); clear = 1'b0;
    cycles(5);

    // Idle threshold of two units; SCL dropped at tick 20 restarts it.
    idle_limit = IDLE_W'(2);
    scl = 1'b0; cycle(); scl = 1'b1;
    cycles(40);
    scl = 1'b0; cycle(); scl = 1'b1;
    cycles(20);
    scl = 1'b0; cycle(); scl = 1'b1;
    cycles(40);
    idle_limit = '0;
    cycles(2);

    // Not-idle detector: arm, one-clock SCL low, disarm.
    arm = 1'b1; cycles(3);
    scl = 1'b0; cycle(); scl = 1'b1;
    cycles(4);
    arm = 1'b0; cycles(3);

    // Divisor change mid-period takes effect at the next reload.
    div_limit = DIV_W'(39);
    clear = 1'b1; cycle(); clear = 1'b0;
    cycles(20);
    div_limit = DIV_W'(3);
    cycles(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(199) == 0);
      clear = ($urandom_range(49) == 0);
      if (clear && $urandom_range(3) == 0) cmp_sticky = NCMP'($urandom);
      run = ($urandom_range(9) != 0);
      if ($urandom_range(99) == 0)  div_limit = DIV_W'($urandom_range(5));
      if ($urandom_range(199) == 0) cmp_limit = (NCMP*CNT_W)'({$urandom, $urandom});
      scl        = ($urandom_range(199) != 0);
      idle_reset = ($urandom_range(149) == 0);
      if ($urandom_range(49) == 0)  arm = ~arm;
      if ($urandom_range(149) == 0) idle_limit = IDLE_W'($urandom_range(3));
      cycle();
    end

    // Final reset overriding in-flight state.
    rst = 1'b1; clear = 1'b0; cycles(2);
    rst = 1'b0; cycles(3);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
